// File: rtl/sensor_pkg.sv
// Shared types and default constants for the ultrasonic range sensor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sensor_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_e;

  // Defaults for the 50 MHz board clock
  localparam int DEF_TRIG_CYCLES   = 500;      // 10 us trigger pulse
  localparam int DEF_PERIOD_CYCLES = 3000000;  // 60 ms between triggers
  localparam int DEF_CYCLES_PER_CM = 2900;     // 58 us of echo per cm
  localparam int DEF_ECHO_TIMEOUT  = 1900000;  // 38 ms give-up time

  // Width of every counter; covers the full period count
  localparam int CNT_W = 22;

  // Clamp a quotient to the 8-bit LED range
  function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
    return (|v[CNT_W-1:8]) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/hcsr04_driver.sv
// Trigger/echo sequencer with echo-width counter and serial divider to centimetres.
// Latency: result posted 24 clocks after the synced echo falls (22-step divider).
// Backpressure: none; results are held until replaced, enable low parks in IDLE.
module hcsr04_driver
  import sensor_pkg::*;
#(
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
  parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       echo_i,
  output logic       trig_o,
  output logic       busy_o,
  output logic [7:0] width_cm_o,
  output logic       valid_o,
  output logic       timeout_o
);

  localparam int DW = CNT_W + 1;
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX      = CNT_W'(ECHO_TIMEOUT);
  localparam logic [DW-1:0]    DIVISOR     = DW'(CYCLES_PER_CM);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q;   // clocks since TRIG entry
  logic [CNT_W-1:0] cnt_q;      // trigger length / echo wait counter
  logic [CNT_W-1:0] width_q;    // echo high time
  logic             echo_d_q;
  logic [CNT_W-1:0] div_rem_q;
  logic [CNT_W-1:0] div_quo_q;  // holds the dividend, shifts out into the quotient
  logic [4:0]       div_cnt_q;
  logic             div_busy_q;
  logic [7:0]       cm_q;
  logic             valid_q;
  logic             timeout_q;

  logic             echo_rise;
  logic             to_trig, to_wait, to_meas, do_timeout, do_fall;
  logic [DW-1:0]    rem_sh;
  logic             rem_ge;

  assign echo_rise = echo_i & ~echo_d_q;

  // Next-state decode and one-cycle event strobes for the datapath
  always_comb begin
    state_d    = state_q;
    to_trig    = 1'b0;
    to_wait    = 1'b0;
    to_meas    = 1'b0;
    do_timeout = 1'b0;
    do_fall    = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = TRIG;
          to_trig = 1'b1;
        end
        TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            state_d = WAIT_ECHO;
            to_wait = 1'b1;
          end
        end
        WAIT_ECHO: begin
          // an echo already high here has no rising edge and is ignored
          if (echo_rise) begin
            state_d = MEASURE;
            to_meas = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_d    = HOLDOFF;
            do_timeout = 1'b1;
          end
        end
        MEASURE: begin
          if (!echo_i) begin
            state_d = HOLDOFF;
            do_fall = 1'b1;
          end else if (width_q >= TO_MAX) begin
            state_d    = HOLDOFF;
            do_timeout = 1'b1;
          end
        end
        HOLDOFF: begin
          // a long echo may already have used up the period: retrigger at once
          if (period_q >= PERIOD_LAST) begin
            state_d = TRIG;
            to_trig = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One restoring-division step: shift in the next dividend bit, try to subtract
  always_comb begin
    rem_sh = {div_rem_q, div_quo_q[CNT_W-1]};
    rem_ge = (rem_sh >= DIVISOR);
  end

  // State, counters, divider and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      period_q   <= '0;
      cnt_q      <= '0;
      width_q    <= '0;
      echo_d_q   <= 1'b0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_cnt_q  <= '0;
      div_busy_q <= 1'b0;
      cm_q       <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      echo_d_q <= echo_i;

      if (to_trig) begin
        period_q <= '0;
      end else if (period_q != '1) begin
        period_q <= period_q + 1'b1;
      end

      if (to_trig || to_wait) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // the rising-edge cycle is already the first high clock
      if (to_meas) begin
        width_q <= CNT_W'(1);
      end else if (state_q == MEASURE && echo_i) begin
        width_q <= width_q + 1'b1;
      end

      if (do_fall) begin
        div_rem_q  <= '0;
        div_quo_q  <= width_q;
        div_cnt_q  <= 5'(CNT_W);
        div_busy_q <= 1'b1;
      end else if (div_busy_q) begin
        if (div_cnt_q == 5'd0) begin
          cm_q       <= sat8(div_quo_q);
          valid_q    <= 1'b1;
          timeout_q  <= 1'b0;
          div_busy_q <= 1'b0;
        end else begin
          div_rem_q <= rem_ge ? CNT_W'(rem_sh - DIVISOR) : rem_sh[CNT_W-1:0];
          div_quo_q <= {div_quo_q[CNT_W-2:0], rem_ge};
          div_cnt_q <= div_cnt_q - 5'd1;
        end
      end

      if (do_timeout) begin
        cm_q       <= 8'hFF;
        valid_q    <= 1'b0;
        timeout_q  <= 1'b1;
        div_busy_q <= 1'b0;
      end
    end
  end

  // trigger is gated by enable so it drops in the same cycle enable falls
  assign trig_o     = (state_q == TRIG) && enable_i;
  assign busy_o     = (state_q != IDLE) || div_busy_q;
  assign width_cm_o = cm_q;
  assign valid_o    = valid_q;
  assign timeout_o  = timeout_q;

endmodule

// File: rtl/top_level.sv
// Board top: key/echo synchronisers, GPIO trigger pin and LED status mapping.
// Latency: 2-clock synchronisers on reset, enable and echo.
// Backpressure: none.
module top_level
  import sensor_pkg::*;
#(
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
  parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  inout  wire  [35:0] GPIO,
  output logic [7:0]  LEDR,
  output logic [7:0]  LEDG
);

  logic rst_meta_q, rst_q;
  logic en_meta_q, enable;
  logic echo_meta_q, echo_s;
  logic trig, busy, valid, timeout;
  logic [7:0] width_cm;
  logic unused_sink;

  // Reset synchroniser: the pushbutton is asynchronous to the clock
  always_ff @(posedge CLOCK_50) begin
    rst_meta_q <= ~KEY[2];
    rst_q      <= rst_meta_q;
  end

  // Enable and echo synchronisers
  always_ff @(posedge CLOCK_50) begin
    if (rst_q) begin
      en_meta_q   <= 1'b0;
      enable      <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s      <= 1'b0;
    end else begin
      en_meta_q   <= ~KEY[0];
      enable      <= en_meta_q;
      echo_meta_q <= GPIO[34];
      echo_s      <= echo_meta_q;
    end
  end

  hcsr04_driver #(
    .TRIG_CYCLES  (TRIG_CYCLES),
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .CYCLES_PER_CM(CYCLES_PER_CM),
    .ECHO_TIMEOUT (ECHO_TIMEOUT)
  ) u_drv (
    .clk_i     (CLOCK_50),
    .rst_i     (rst_q),
    .enable_i  (enable),
    .echo_i    (echo_s),
    .trig_o    (trig),
    .busy_o    (busy),
    .width_cm_o(width_cm),
    .valid_o   (valid),
    .timeout_o (timeout)
  );

  assign GPIO[35]   = trig;
  assign GPIO[33:0] = {34{1'bz}};

  assign LEDR = width_cm;
  assign LEDG = {4'b0000, trig, timeout, valid, echo_s};

  assign unused_sink = ^{KEY[3], KEY[1], busy};

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;
  import sensor_pkg::*;

  localparam int TRIG   = 500;
  localparam int PERIOD = 4000;
  localparam int CPCM   = 10;
  localparam int TMO    = 3000;

  logic        clk = 1'b0;
  logic [3:0]  key = 4'b1011;
  logic        echo_drv = 1'b0;
  wire  [35:0] gpio;
  logic [7:0]  ledr, ledg;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  assign gpio[34] = echo_drv;

  top_level #(
    .TRIG_CYCLES  (TRIG),
    .PERIOD_CYCLES(PERIOD),
    .CYCLES_PER_CM(CPCM),
    .ECHO_TIMEOUT (TMO)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .GPIO    (gpio),
    .LEDR    (ledr),
    .LEDG    (ledg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         width;     // echo clocks, 0 = no echo at all
    logic [7:0] exp_cm;
    logic       exp_valid;
    logic       exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_trig(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (gpio[35] === level) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // catch a trigger pulse, answer with an echo of 'width' clocks, check the result
  task automatic measure(input string name, input int width, input logic [7:0] cm,
                         input logic vld, input logic to);
    bit ok;
    wait_trig(1'b1, PERIOD + 200, ok);
    check({name, "_trig_seen"}, 32'(ok), 32'd1);
    wait_trig(1'b0, TRIG + 50, ok);
    check({name, "_trig_end"}, 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    if (width > 0) begin
      echo_drv = 1'b1;
      repeat (width) @(negedge clk);
      echo_drv = 1'b0;
      repeat (32) @(negedge clk);
    end else begin
      repeat (TMO + 100) @(negedge clk);
    end
    check({name, "_ledr"}, 32'(ledr), 32'(cm));
    check({name, "_valid"}, 32'(ledg[1]), 32'(vld));
    check({name, "_timeout"}, 32'(ledg[2]), 32'(to));
  endtask

  initial begin
    bit ok;
    int t_rise;
    int w;

    vecs[0] = '{100,  8'd10,  1'b1, 1'b0};
    vecs[1] = '{5,    8'd0,   1'b1, 1'b0};   // shorter than one cm
    vecs[2] = '{10,   8'd1,   1'b1, 1'b0};   // exactly one cm
    vecs[3] = '{2600, 8'd255, 1'b1, 1'b0};   // 260 cm saturates
    vecs[4] = '{2559, 8'd255, 1'b1, 1'b0};   // exactly 255
    vecs[5] = '{2549, 8'd254, 1'b1, 1'b0};
    vecs[6] = '{0,    8'hFF,  1'b0, 1'b1};   // no echo: timeout
    vecs[7] = '{37,   8'd3,   1'b1, 1'b0};   // good echo clears timeout

    // reset with enable released
    repeat (5) @(negedge clk);
    check("rst_ledr", 32'(ledr), 32'd0);
    check("rst_ledg", 32'(ledg), 32'd0);
    check("rst_trig", 32'(gpio[35]), 32'd0);
    key = 4'b1111;
    repeat (100) @(negedge clk);
    check("idle_trig", 32'(gpio[35]), 32'd0);
    check("idle_ledg", 32'(ledg), 32'd0);

    // trigger width and period
    key = 4'b1110;
    wait_trig(1'b1, 50, ok);
    check("first_trig", 32'(ok), 32'd1);
    t_rise = cyc;
    wait_trig(1'b0, TRIG + 50, ok);
    check("trig_width", 32'(cyc - t_rise), 32'(TRIG));
    wait_trig(1'b1, PERIOD + 50, ok);
    check("trig_period", 32'(cyc - t_rise), 32'(PERIOD));

    for (int i = 0; i < 8; i++)
      measure($sformatf("vec%0d", i), vecs[i].width, vecs[i].exp_cm,
              vecs[i].exp_valid, vecs[i].exp_to);

    // enable drop in the middle of an echo
    wait_trig(1'b1, PERIOD + 200, ok);
    wait_trig(1'b0, TRIG + 50, ok);
    repeat (20) @(negedge clk);
    echo_drv = 1'b1;
    repeat (200) @(negedge clk);
    key = 4'b1111;
    repeat (5) @(negedge clk);
    check("drop_state", 32'(dut.u_drv.state_q), 32'(IDLE));
    check("drop_trig", 32'(gpio[35]), 32'd0);
    echo_drv = 1'b0;
    repeat (50) @(negedge clk);
    check("drop_ledr", 32'(ledr), 32'd3);
    check("drop_valid", 32'(ledg[1]), 32'd1);
    key = 4'b1110;
    wait_trig(1'b1, 10, ok);
    check("reenable_trig", 32'(ok), 32'd1);

    // random echo widths, expected value from integer division
    for (int i = 0; i < 5; i++) begin
      w = $urandom_range(25, 2525);
      measure($sformatf("rnd%0d", i), w, 8'((w / CPCM) > 255 ? 255 : (w / CPCM)),
              1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
